// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        i_dmem_ren;
    logic        i_dmem_wen;
    logic        o_dmem_ready;
    logic [31:0] o_dmem_rdata;
    logic        o_dmem_valid;
    logic        o_dmem_err;

    modport master (
        output i_dmem_addr, i_dmem_wdata, i_dmem_mask, i_dmem_ren, i_dmem_wen,
        input  o_dmem_ready, o_dmem_rdata, o_dmem_valid, o_dmem_err
    );
    modport slave (
        input  i_dmem_addr, i_dmem_wdata, i_dmem_mask, i_dmem_ren, i_dmem_wen,
        output o_dmem_ready, o_dmem_rdata, o_dmem_valid, o_dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked single-cycle writes, fixed-latency reads,
// range/malformed-request error pulses. One outstanding read at a time.
module dmem_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dmem_responder_if.slave bus
);
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state, state_nx;
    logic [2:0]          cnt, cnt_nx;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         off;
    logic                in_rng;
    logic [ADDR_W-1:0]   idx;
    logic                ready, accept, is_rd, is_wr, is_both, fire;
    logic [31:0]         rd_word;
    logic [31:0]         pend_data, rdata_q;
    logic                pend_oor, valid_q, err_q;

    // Offset wraps mod 2^32, so addresses below BASE_ADDR land far out of range.
    assign off     = bus.i_dmem_addr - BASE_ADDR;
    assign in_rng  = {1'b0, off} < SPAN;
    assign idx     = off[ADDR_W+1:2];
    assign is_rd   = bus.i_dmem_ren & ~bus.i_dmem_wen;
    assign is_wr   = bus.i_dmem_wen & ~bus.i_dmem_ren;
    assign is_both = bus.i_dmem_ren & bus.i_dmem_wen;
    assign ready   = (state != S_WAIT);
    assign accept  = (bus.i_dmem_ren | bus.i_dmem_wen) & ready;
    assign rd_word = in_rng ? mem[idx] : 32'h0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // RESP behaves like IDLE for new requests, which gives back-to-back reads.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fire     = 1'b0;
        case (state)
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nx = S_RESP;
                    fire     = 1'b1;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                if (accept && is_rd && LATENCY > 1) begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q   <= 32'h0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            pend_data <= 32'h0;
            pend_oor  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (accept) begin
                if (is_rd) begin
                    if (LATENCY == 1) begin
                        valid_q <= 1'b1;
                        rdata_q <= rd_word;
                        err_q   <= ~in_rng;
                    end else begin
                        pend_data <= rd_word;
                        pend_oor  <= ~in_rng;
                    end
                end else if (is_both || (is_wr && !in_rng)) begin
                    err_q <= 1'b1;
                end
            end
            if (fire) begin
                valid_q <= 1'b1;
                rdata_q <= pend_data;
                err_q   <= pend_oor;
            end
        end
    end

    // Array has no reset; writes are held off while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept && is_wr && in_rng) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.i_dmem_mask[b]) mem[idx][8*b +: 8] <= bus.i_dmem_wdata[8*b +: 8];
            end
        end
    end

    assign bus.o_dmem_ready = ready;
    assign bus.o_dmem_rdata = rdata_q;
    assign bus.o_dmem_valid = valid_q;
    assign bus.o_dmem_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a cycle-indexed event model.
module tb_dmem_responder;
    localparam int          AW   = 10;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );

    typedef struct {
        int          c;
        bit          v;
        bit          e;
        logic [31:0] d;
        logic [3:0]  km;
    } ev_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          busy_lo = 0;
    int          busy_hi = -1;
    logic [31:0] mm [1 << AW];
    logic [3:0]  mk [1 << AW];
    ev_t         evq [$];
    logic [31:0] last_d = 32'h0;
    logic [3:0]  last_k = 4'hF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] bm(input logic [3:0] k);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{k[b]}};
        return r;
    endfunction

    function automatic bit rdy_exp(input int c);
        return !(c >= busy_lo && c <= busy_hi);
    endfunction

    // Cycle c is the cycle after rising edge c; checks every output against the model.
    task automatic compare();
        bit          ev_v = 1'b0;
        bit          ev_e = 1'b0;
        logic [31:0] m32;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].c == cyc) begin
                if (evq[i].v) begin
                    ev_v   = 1'b1;
                    last_d = evq[i].d;
                    last_k = evq[i].km;
                end
                if (evq[i].e) ev_e = 1'b1;
                evq.delete(i);
            end
        end
        chk("ready", 32'(bus.o_dmem_ready), 32'(rdy_exp(cyc)));
        chk("valid", 32'(bus.o_dmem_valid), 32'(ev_v));
        chk("err",   32'(bus.o_dmem_err),   32'(ev_e));
        m32 = bm(last_k);
        chk("rdata", bus.o_dmem_rdata & m32, last_d & m32);
    endtask

    task automatic step(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
        int          k;
        int          idx;
        logic [31:0] off;
        bit          inr;
        bus.i_dmem_ren   = ren;
        bus.i_dmem_wen   = wen;
        bus.i_dmem_addr  = a;
        bus.i_dmem_wdata = wd;
        bus.i_dmem_mask  = m;
        k = cyc + 1;
        if ((ren || wen) && rdy_exp(cyc)) begin
            off = a - BASE;
            inr = ({1'b0, off} < (33'd4 << AW));
            idx = int'(off[AW+1:2]);
            if (ren && wen) begin
                evq.push_back('{c: k, v: 1'b0, e: 1'b1, d: 32'h0, km: 4'h0});
            end else if (wen) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m[b]) begin
                            mm[idx][8*b +: 8] = wd[8*b +: 8];
                            mk[idx][b] = 1'b1;
                        end
                    end
                end else begin
                    evq.push_back('{c: k, v: 1'b0, e: 1'b1, d: 32'h0, km: 4'h0});
                end
            end else begin
                evq.push_back('{c: k + LAT - 1, v: 1'b1, e: !inr,
                                d: inr ? mm[idx] : 32'h0, km: inr ? mk[idx] : 4'hF});
                busy_lo = k;
                busy_hi = k + LAT - 2;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b0, 1'b1, a, d, m);
    endtask

    // Issue a read and pin the returned word to a hand-computed literal.
    task automatic rd_lit(input string nm, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        step(1'b1, 1'b0, a, 32'h0, 4'h0);
        while (!bus.o_dmem_valid && n < 10) begin
            idle();
            n++;
        end
        chk({nm, "_seen"},  32'(bus.o_dmem_valid), 32'h1);
        chk({nm, "_rdata"}, bus.o_dmem_rdata, exp_d);
        chk({nm, "_err"},   32'(bus.o_dmem_err), 32'(exp_e));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mk[i] = 4'h0;
        bus.i_dmem_ren   = 1'b0;
        bus.i_dmem_wen   = 1'b0;
        bus.i_dmem_addr  = 32'h0;
        bus.i_dmem_wdata = 32'h0;
        bus.i_dmem_mask  = 4'h0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", 32'(bus.o_dmem_ready), 32'h1);
        chk("rst_valid", 32'(bus.o_dmem_valid), 32'h0);
        chk("rst_rdata", bus.o_dmem_rdata, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        compare();

        // full write then read-after-write, then partial and empty masks
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd_lit("raw", 32'h10, 32'hDEADBEEF, 1'b0);
        wr(32'h10, 32'h0000AA00, 4'b0010);
        rd_lit("mask2", 32'h10, 32'hDEADAAEF, 1'b0);
        wr(32'h10, 32'hFFFFFFFF, 4'b0000);
        rd_lit("mask0", 32'h10, 32'hDEADAAEF, 1'b0);

        // latency window: ready low two cycles, then valid with ready and a back-to-back read
        wr(32'h20, 32'h12345678, 4'hF);
        step(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("lat_rdy1", 32'(bus.o_dmem_ready), 32'h0);
        idle();
        chk("lat_rdy2", 32'(bus.o_dmem_ready), 32'h0);
        idle();
        chk("lat_valid", 32'(bus.o_dmem_valid), 32'h1);
        chk("lat_rdy3",  32'(bus.o_dmem_ready), 32'h1);
        chk("lat_rdata", bus.o_dmem_rdata, 32'h12345678);
        step(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("b2b_taken", 32'(bus.o_dmem_ready), 32'h0);
        idle();
        idle();
        chk("b2b_rdata", bus.o_dmem_rdata, 32'hDEADAAEF);

        // out-of-range read/write, and malformed ren&wen
        wr(32'h0, 32'hCAFEF00D, 4'hF);
        rd_lit("oor_rd", 32'h1000, 32'h0, 1'b1);
        wr(32'h1000, 32'h11111111, 4'hF);
        chk("oor_wr_err", 32'(bus.o_dmem_err), 32'h1);
        rd_lit("oor_alias", 32'h0, 32'hCAFEF00D, 1'b0);
        wr(32'h8, 32'h55AA55AA, 4'hF);
        step(1'b1, 1'b1, 32'h8, 32'h0, 4'hF);
        chk("both_err",   32'(bus.o_dmem_err),   32'h1);
        chk("both_valid", 32'(bus.o_dmem_valid), 32'h0);
        rd_lit("both_keep", 32'h8, 32'h55AA55AA, 1'b0);

        // randomized traffic, including ignored requests while busy
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int r  = $urandom_range(0, 9);
            int op = $urandom_range(0, 7);
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            case (op)
                0:       idle();
                1:       step(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
                2, 3, 4: step(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
                default: step(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            endcase
        end
        repeat (4) idle();

        // asynchronous reset in the middle of a pending read
        step(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        bus.i_dmem_ren = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_ready", 32'(bus.o_dmem_ready), 32'h1);
        chk("mid_valid", 32'(bus.o_dmem_valid), 32'h0);
        chk("mid_err",   32'(bus.o_dmem_err),   32'h0);
        chk("mid_rdata", bus.o_dmem_rdata, 32'h0);
        evq.delete();
        busy_lo = 0;
        busy_hi = -1;
        last_d  = 32'h0;
        last_k  = 4'hF;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        i_rst = 1'b0;
        compare();
        repeat (6) idle();
        rd_lit("post_rst", 32'h20, 32'h12345678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage core: the memory-side end of the memory stage's dmem request interface.
- Accepts word-aligned requests: address, byte-lane mask, write data, ren/wen.
- Performs byte-masked writes into a local word array; returns full read words after a configurable latency.
- Flags out-of-range and malformed requests.
- Sits between the memory stage and the MEM/WB read-data path; instantiated once per core in simulation and FPGA builds.

Parameters:
- ADDR_W, 10, word-address bits; array holds 2^ADDR_W 32-bit words.
- LATENCY, 1, cycles from request cycle to read-data-valid cycle; legal range 1..8.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- i_clk  input  1  core clock; all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_dmem_addr  input  32  byte address; bits [1:0] ignored (requester pre-aligns).
- i_dmem_wdata  input  32  write data, already lane-shifted by requester.
- i_dmem_mask  input  4  byte-lane enables for writes; bit n = byte n.
- i_dmem_ren  input  1  read request.
- i_dmem_wen  input  1  write request.
- o_dmem_ready  output  1  responder can accept a request this cycle.
- o_dmem_rdata  output  32  read word; valid when o_dmem_valid.
- o_dmem_valid  output  1  one-cycle pulse, read data present.
- o_dmem_err  output  1  one-cycle pulse, access error.

Behaviour:
- Reset values, applied asynchronously on i_rst: o_dmem_ready=1, o_dmem_valid=0, o_dmem_rdata=0, o_dmem_err=0, FSM=IDLE, wait counter=0.
- Array contents are not cleared by reset; they are undefined until written.
- Accept condition: (i_dmem_ren|i_dmem_wen) & o_dmem_ready, sampled at rising edge k.
  - Requests presented while o_dmem_ready=0 are ignored, not queued; the requester holds them.
- Offset and range check:
  - off = i_dmem_addr - BASE_ADDR, computed in 32-bit unsigned arithmetic (wraps mod 2^32).
  - In range iff off < 4*2^ADDR_W.
  - Word index = off[ADDR_W+1:2].
- Write (wen=1, ren=0, in range):
  - Bytes with mask=1 are updated at edge k; other bytes are unchanged.
  - mask=4'b0000 is a legal no-op with no error.
  - o_dmem_ready stays 1; writes always complete in one cycle.
- Read (ren=1, wen=0, in range):
  - The word is sampled from the array at edge k, so it includes a write accepted at edge k-1 (read-after-write is coherent).
  - The sample goes through a LATENCY-deep hold.
  - o_dmem_valid=1 and o_dmem_rdata=word during exactly the cycle after edge k+LATENCY-1.
  - The mask is ignored for reads; the full word is returned.
- FSM states:
  - IDLE: ready=1. On a read accept with LATENCY=1, stay in IDLE; valid pulses the next cycle.
  - IDLE: on a read accept with LATENCY>1, go to WAIT with cnt=LATENCY-2.
  - WAIT: ready=0. Each edge: if cnt==0, go to RESP; else cnt-=1.
  - RESP: valid=1, ready=1. It can accept a new request in the same cycle (back-to-back), then transitions as IDLE would.
  - Net effect: ready is low for exactly LATENCY-1 cycles per read; LATENCY=1 gives full throughput.
- o_dmem_rdata holds its last read value when valid=0; it updates only on valid cycles.
- Errors (o_dmem_err pulses for one cycle):
  - Out-of-range write: dropped; err in the cycle after edge k.
  - Out-of-range read: normal read timing, with rdata=0 and err asserted together with valid.
  - ren & wen both high: no array access, no valid; err in the cycle after edge k; ready unaffected.
- Reset mid-WAIT: the pending read is discarded; no valid or err is ever emitted for it; ready=1 immediately.

Test Plan:
- Write 32'hDEADBEEF mask 4'hF to addr 0x10, then read 0x10 next cycle (LATENCY=1) -> valid the cycle after the read request, rdata=32'hDEADBEEF, ready never low.
- Over existing 32'hDEADBEEF at 0x10, write 32'h0000AA00 mask 4'b0010, then read -> rdata=32'hDEADAAEF; write with mask 4'b0000 then read -> unchanged.
- LATENCY=3, read 0x20 holding 32'h12345678 at edge k -> ready low in the cycles after edges k and k+1; valid+rdata=32'h12345678 in the cycle after edge k+2 with ready=1; a second read in that cycle is accepted.
- ADDR_W=10, BASE=0, read 0x1000 -> valid with rdata=0 and err=1 together; write 0x1000 -> err pulse next cycle, array unchanged at 0x0.
- ren=wen=1 at 0x8 -> err pulse, no valid, word at 0x8 unchanged.
- LATENCY=4: assert i_rst asynchronously mid-WAIT -> ready=1, valid=0, err=0, rdata=0 immediately; no valid pulse afterwards.
